inscache: RTL and testbench

- Direct-mapped, read-only instruction cache that answers the fetch unit's out_PC / ask_for requests with give_you / g_ins.
- Supports RV32C: every halfword-aligned PC is served, including a 32-bit instruction that straddles two lines.
- Misses are refilled from the memory controller as whole lines over a word-stream request interface.

---
 rtl/inscache.sv | 152 +++++++++++++++
 tb/tb_inscache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inscache.sv
// Direct-mapped read-only instruction cache with RV32C halfword lookup and line-straddle support.
// Optional next-line prefetch after demand fills when ICACHE_NEXTLINE_PREFETCH_EN is defined.
module inscache #(
    parameter int INDEX_BITS = 5,
    parameter int LINE_BITS  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] in_PC,
    input  logic        ask_for,
    output logic        give_you,
    output logic [31:0] g_ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_word_valid,
    input  logic [31:0] mem_word
);
    localparam int SETS       = 1 << INDEX_BITS;
    localparam int LINE_WORDS = 1 << (LINE_BITS - 2);
    localparam int WOFF_BITS  = LINE_BITS - 2;
    localparam int TAG_LO     = INDEX_BITS + LINE_BITS;
    localparam int TAG_BITS   = 32 - TAG_LO;
    localparam logic [WOFF_BITS-1:0] C_LAST = WOFF_BITS'(LINE_WORDS - 1);
    localparam logic [WOFF_BITS-1:0] C_ONE  = WOFF_BITS'(1);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                r_state;
    logic [SETS-1:0]       r_valid;
    logic [TAG_BITS-1:0]   r_tag  [SETS];
    logic [31:0]           r_data [SETS][LINE_WORDS];
    logic [WOFF_BITS-1:0]  r_cnt;
    logic [INDEX_BITS-1:0] r_fill_idx;
    logic [TAG_BITS-1:0]   r_fill_tag;
    logic                  r_mem_req;
    logic [31:0]           r_mem_addr;

    logic [31:0]           w_pc2;
    logic [INDEX_BITS-1:0] w_idx0, w_idx1;
    logic [TAG_BITS-1:0]   w_tag0, w_tag1;
    logic [31:0]           w_word0, w_word1;
    logic [15:0]           w_lo, w_hi;
    logic                  w_hit0, w_hit1, w_is32, w_hit, w_busy;
    logic                  w_need_fill, w_last, w_pf_start, w_start;
    logic [31:0]           w_tgt_addr, w_start_addr;
    logic                  w_unused;

    // The second halfword lives at in_PC+2, which may sit in the next line.
    assign w_pc2   = in_PC + 32'd2;
    assign w_idx0  = in_PC[TAG_LO-1:LINE_BITS];
    assign w_tag0  = in_PC[31:TAG_LO];
    assign w_idx1  = w_pc2[TAG_LO-1:LINE_BITS];
    assign w_tag1  = w_pc2[31:TAG_LO];
    assign w_word0 = r_data[w_idx0][in_PC[LINE_BITS-1:2]];
    assign w_word1 = r_data[w_idx1][w_pc2[LINE_BITS-1:2]];
    assign w_lo    = in_PC[1] ? w_word0[31:16] : w_word0[15:0];
    assign w_hi    = w_pc2[1] ? w_word1[31:16] : w_word1[15:0];
    assign w_is32  = (w_lo[1:0] == 2'b11);
    assign w_hit0  = r_valid[w_idx0] && (r_tag[w_idx0] == w_tag0);
    assign w_hit1  = r_valid[w_idx1] && (r_tag[w_idx1] == w_tag1);
    assign w_hit   = w_hit0 && (!w_is32 || w_hit1);
    assign w_busy  = (r_state == S_FILL) &&
                     ((w_idx0 == r_fill_idx) || (w_is32 && (w_idx1 == r_fill_idx)));

    assign give_you = ask_for && rdy_in && rst_in && w_hit && !w_busy;
    assign g_ins    = !give_you ? 32'h0 : (w_is32 ? {w_hi, w_lo} : {16'h0, w_lo});
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    always_comb begin
        w_need_fill = 1'b0;
        w_tgt_addr  = in_PC;
        if (ask_for && !w_hit0) begin
            w_need_fill = 1'b1;
        end else if (ask_for && w_is32 && !w_hit1) begin
            w_need_fill = 1'b1;
            w_tgt_addr  = w_pc2;
        end
    end

    assign w_last = (r_state == S_FILL) && mem_word_valid && (r_cnt == C_LAST);

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    logic                  r_pf;
    logic [31:0]           w_nl_addr;
    logic [INDEX_BITS-1:0] w_nl_idx;
    logic                  w_nl_hit;

    assign w_nl_addr    = r_mem_addr + 32'(1 << LINE_BITS);
    assign w_nl_idx     = w_nl_addr[TAG_LO-1:LINE_BITS];
    assign w_nl_hit     = r_valid[w_nl_idx] && (r_tag[w_nl_idx] == w_nl_addr[31:TAG_LO]);
    // Only a completing demand fill may chain into a prefetch.
    assign w_pf_start   = w_last && !r_pf && !w_nl_hit;
    assign w_start_addr = w_pf_start ? w_nl_addr : w_tgt_addr;
`else
    assign w_pf_start   = 1'b0;
    assign w_start_addr = w_tgt_addr;
`endif

    assign w_start  = rdy_in && (((r_state == S_IDLE) && w_need_fill) || w_pf_start);
    assign w_unused = ^{in_PC[0], w_pc2[0], w_start_addr[LINE_BITS-1:0]};

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_cnt      <= '0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
            r_pf       <= 1'b0;
`endif
        end else if (rdy_in) begin
            if ((r_state == S_FILL) && mem_word_valid) begin
                r_cnt <= r_cnt + C_ONE;
                if (r_cnt == C_LAST) begin
                    r_valid[r_fill_idx] <= 1'b1;
                    r_mem_req           <= 1'b0;
                    r_state             <= S_IDLE;
                end
            end
            // A new fill invalidates its target so no partial line can ever hit.
            if (w_start) begin
                r_state    <= S_FILL;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_start_addr[31:LINE_BITS], {LINE_BITS{1'b0}}};
                r_cnt      <= '0;
                r_fill_idx <= w_start_addr[TAG_LO-1:LINE_BITS];
                r_fill_tag <= w_start_addr[31:TAG_LO];
                r_valid[w_start_addr[TAG_LO-1:LINE_BITS]] <= 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
                r_pf       <= w_pf_start;
`endif
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && (r_state == S_FILL) && mem_word_valid) begin
            r_data[r_fill_idx][r_cnt] <= mem_word;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && w_last) begin
            r_tag[r_fill_idx] <= r_fill_tag;
        end
    end
endmodule

// File: tb/tb_inscache.sv
// Bench for inscache: random fetch stream against a memory image and a line-residency model,
// with a decoupled monitor popping expected instructions whenever give_you is seen.
module tb_inscache;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] in_PC = 32'h0;
    logic        ask_for = 1'b0;
    logic        give_you;
    logic [31:0] g_ins;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_word_valid = 1'b0;
    logic [31:0] mem_word = 32'h0;

    inscache #(.INDEX_BITS(5), .LINE_BITS(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .in_PC(in_PC),
        .ask_for(ask_for), .give_you(give_you), .g_ins(g_ins), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_word_valid(mem_word_valid), .mem_word(mem_word)
    );

    // Clock and cycle counter
    always #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc++;

    logic [31:0] mem [1024];
    logic [31:0] exp_q[$];
    logic [31:0] fill_log[$];
    bit          slot_v [32];
    logic [31:0] slot_line [32];
    int          n_vec = 0, n_err = 0, n_served = 0;
    int          bcnt = 0, serve_cyc = 0, last_word_cyc = 0;
    logic        serve_mreq = 1'b0, prev_mreq = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [9:0]  wi;
    int          t, st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] exp_ins(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw(pc);
        if (lo[1:0] == 2'b11) return {hw(pc + 32'd2), lo};
        return {16'h0, lo};
    endfunction

    function automatic bit model_res(input logic [31:0] line);
        return slot_v[line[8:4]] && (slot_line[line[8:4]] == line);
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    endtask

    // Memory controller: streams the requested line with random gaps, never while rdy_in is low.
    always @(posedge clk_in) begin
        #2;
        mem_word_valid = 1'b0;
        if (!rst_in) begin
            bcnt = 0;
        end else if (mem_req && rdy_in && $urandom_range(0, 3) != 0) begin
            wi = mem_addr[11:2] + 10'(bcnt);
            mem_word = mem[wi];
            mem_word_valid = 1'b1;
            bcnt++;
            if (bcnt == 4) begin
                bcnt = 0;
                slot_v[mem_addr[8:4]] = 1'b1;
                slot_line[mem_addr[8:4]] = mem_addr;
                last_word_cyc = cyc;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (give_you === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_give", 32'(give_you), 32'h0);
                end else begin
                    check("g_ins", g_ins, exp_q.pop_front());
                end
                serve_cyc = cyc;
                serve_mreq = mem_req;
                n_served++;
            end else begin
                check("g_ins_idle_zero", g_ins, 32'h0);
            end
            if (mem_req && !prev_mreq) fill_log.push_back(mem_addr);
            if (mem_req && prev_mreq) check("mem_addr_stable", mem_addr, prev_addr);
        end
        prev_mreq = mem_req;
        prev_addr = mem_addr;
    end

    task automatic do_reset();
        rst_in = 1'b0; ask_for = 1'b1; in_PC = 32'h0; rdy_in = 1'b1;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("reset_give_you", 32'(give_you), 32'h0);
        check("reset_g_ins", g_ins, 32'h0);
        check("reset_mem_req", 32'(mem_req), 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        @(posedge clk_in); #1;
        exp_q.delete();
        fill_log.delete();
        foreach (slot_v[i]) slot_v[i] = 1'b0;
        rst_in = 1'b1; ask_for = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (bcnt < n && k < 100) begin
            @(posedge clk_in); #1;
            k++;
        end
        check("wait_words_timeout", 32'(k < 100), 32'h1);
    endtask

    task automatic fetch(input logic [31:0] pc, input int stall_at);
        logic [31:0] l0, l1, held;
        logic [15:0] lo;
        logic [31:0] exp_fills[$];
        int          start, k;
        bit          rand_low, stalled;
        l0 = {pc[31:4], 4'h0};
        l1 = pc + 32'd2;
        l1[3:0] = 4'h0;
        lo = hw(pc);
        if (!model_res(l0)) exp_fills.push_back(l0);
        if (lo[1:0] == 2'b11 && l1 != l0 && !model_res(l1)) exp_fills.push_back(l1);
        fill_log.delete();
        start = n_served; rand_low = 0; stalled = 0; held = 32'h0;
        exp_q.push_back(exp_ins(pc));
        in_PC = pc; ask_for = 1'b1; rdy_in = 1'b1;
        @(negedge clk_in);
        check("first_cycle_hit", 32'(give_you), 32'(exp_fills.size() == 0));
        k = 0;
        forever begin
            @(posedge clk_in); #1;
            if (n_served != start || k >= 300) break;
            k++;
            if (stall_at >= 0 && !stalled && mem_req && bcnt == stall_at) begin
                stalled = 1; held = mem_addr; rdy_in = 1'b0;
                repeat (3) begin
                    @(negedge clk_in);
                    check("stall_give_you", 32'(give_you), 32'h0);
                    check("stall_mem_req", 32'(mem_req), 32'h1);
                    check("stall_mem_addr", mem_addr, held);
                    @(posedge clk_in); #1;
                end
                rdy_in = 1'b1;
            end else begin
                rdy_in = ($urandom_range(0, 11) != 0);
                if (!rdy_in) rand_low = 1;
            end
        end
        ask_for = 1'b0; rdy_in = 1'b1;
        check("served", 32'(n_served != start), 32'h1);
        if (n_served == start) exp_q.delete();
        check("fill_count", fill_log.size(), exp_fills.size());
        for (int i = 0; i < exp_fills.size() && i < fill_log.size(); i++)
            check("fill_addr", fill_log[i], exp_fills[i]);
        if (n_served != start) begin
            check("mem_req_at_give", 32'(serve_mreq), 32'h0);
            if (exp_fills.size() != 0 && !rand_low)
                check("give_latency", serve_cyc, last_word_cyc + 1);
        end
        if (stall_at >= 0 && exp_fills.size() != 0) check("stall_applied", 32'(stalled), 32'h1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        // Cold miss, 32-bit instruction at 0x0
        init_mem();
        mem[0] = 32'h00000513;
        do_reset();
        fetch(32'h0, -1);

        // Compressed hit in a freshly filled line
        do_reset();
        mem[0] = 32'h45014501;
        fetch(32'h0, -1);
        fetch(32'h2, -1);

        // Straddle with both lines missing
        do_reset();
        mem[3] = {16'h0513, mem[3][15:0]};
        fetch(32'hE, -1);

        // Redirect mid-fill: 0x40 completes, then 0x80 is filled
        do_reset();
        fill_log.delete();
        in_PC = 32'h40; ask_for = 1'b1; rdy_in = 1'b1;
        wait_words(2);
        st = n_served;
        exp_q.push_back(exp_ins(32'h80));
        in_PC = 32'h80;
        t = 0;
        while (n_served == st && t < 200) begin
            @(posedge clk_in); #1;
            t++;
        end
        ask_for = 1'b0;
        check("redirect_served", 32'(n_served != st), 32'h1);
        if (n_served == st) exp_q.delete();
        check("redirect_fill_count", fill_log.size(), 2);
        if (fill_log.size() == 2) begin
            check("redirect_fill0", fill_log[0], 32'h40);
            check("redirect_fill1", fill_log[1], 32'h80);
        end
        fetch(32'h40, -1);

        // Conflict eviction on the same set
        fetch(32'h0, -1);
        fetch(32'h200, -1);
        fetch(32'h0, -1);
        check("conflict_refill", fill_log.size(), 1);

        // rdy_in low mid-fill
        fetch(32'h300, 2);

        // Reset mid-fill abandons the line
        in_PC = 32'h340; ask_for = 1'b1; rdy_in = 1'b1;
        wait_words(2);
        do_reset();
        fetch(32'h340, -1);
        check("post_reset_refill", fill_log.size(), 1);

        // Random fetch stream
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_in); #1;
            end
            fetch(32'($urandom_range(0, 2047)) << 1,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : -1);
        end

        repeat (3) @(posedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
